multiplier_arbiter: RTL
=======================

# multiplier_arbiter

Shares one combinational `multiplier` instance between `NumReq` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request at a time, registers the operands, registers the product one cycle later, and returns it on a single response channel tagged with the requester index. It sits between the compute clients and the multiplier datapath, and is the only owner of that datapath.

## Interface
- `Width`, default 8: operand width in bits; product is `2*Width`.
- `NumReq`, default 4: number of requesters, ≥2.
- `IdW`, default `$clog2(NumReq)`: width of the response tag (derived, not overridden).

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  `NumReq`  per-requester request valid.
- `req_ready_o`  out  `NumReq`  per-requester grant/accept; one-hot or zero.
- `req_a_i`  in  `NumReq*Width`  packed operand A; requester k at `[k*Width +: Width]`.
- `req_b_i`  in  `NumReq*Width`  packed operand B; same packing as `req_a_i`.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accepted by sink.
- `rsp_id_o`  out  `IdW`  index of the requester that owns the response.
- `rsp_data_o`  out  `2*Width`  unsigned product.
- `busy_o`  out  1  high in MUL or RESP.

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - `req_ready_o[k]` = 1 for the arbitration winner k only. This is combinational from `req_valid_i`.
  - On any valid request, latch A, B and k, then go to MUL.
  - If no request is valid, stay in IDLE.
- MUL: register the multiplier output into `rsp_data_o`, then go to RESP.
- RESP:
  - `rsp_valid_o` = 1. `rsp_data_o` and `rsp_id_o` stay stable until accepted.
  - If `rsp_ready_i` = 1, go to IDLE. Otherwise stay in RESP.
- `req_ready_o` is all-zero outside IDLE. Requesters keep `valid` and operands stable until accepted.
- Arithmetic is unsigned and full width with no truncation: `rsp_data_o = A*B` in `2*Width` bits.
- Arbitration is per Configuration. The grant pointer updates only on an accepted request.
- Reset values:
  - `req_ready_o` = 0, `rsp_valid_o` = 0, `rsp_id_o` = 0, `rsp_data_o` = 0, `busy_o` = 0.
  - State = IDLE; operand registers = 0; round-robin pointer = `NumReq-1`, so requester 0 has priority first.
- Reset asserted mid-operation (MUL or RESP) discards the transaction. Outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- Request accepted at edge T (valid & ready) → MUL during cycle T+1 → `rsp_valid_o` high from edge T+2.
- Minimum spacing between accepts is 3 cycles: a response accepted at edge T+2 allows a new accept at edge T+3.
- No combinational path from `rsp_ready_i` to `req_ready_o`.
- The only combinational input→output path is `req_valid_i` → `req_ready_o`.

## Configuration
- Macro: `MULTIPLIER_ARBITER_RR_EN`.
- Defined: round-robin arbitration. Search starts at pointer+1 and wraps modulo `NumReq`. After an accept, the pointer becomes the granted index.
- Undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Package `multiplier_arbiter_pkg`: the FSM state enum typedef (`IDLE`, `MUL`, `RESP`) and the reset pointer constant.
- One sub-module: `multiplier`, instantiated with `Width` and fed from the operand registers.
- Arbitration logic stays inline in `multiplier_arbiter`.

## Test plan
All scenarios use Width=8 and NumReq=4 unless stated.
- **Single request:** requester 2 asserts valid with A=8'hFF, B=8'hFF at cycle 0, `rsp_ready_i`=1. Expect accept at edge 0, then `rsp_valid_o` at edge 2 with `rsp_id_o`=2 and `rsp_data_o`=16'hFE01.
- **Contention:** all four requesters valid continuously, `rsp_ready_i`=1.
  - With the macro: grant order 0,1,2,3,0, one grant every 3 cycles.
  - Without the macro: requester 0 is granted every time.
- **Backpressure:** hold `rsp_ready_i`=0 for 5 cycles in RESP. Expect `rsp_valid_o`, `rsp_id_o` and `rsp_data_o` stable, `req_ready_o`=0, and `busy_o`=1. Release → IDLE on the next edge.
- **Reset mid-operation:** deassert `rst_ni` while in MUL. Expect all outputs 0 immediately. After release, requesters 1 and 3 both valid; with the macro, grant goes to 1 (pointer reset to 3).
- **Edge operands:**
  - A=0, B=8'hA5 → 16'h0000.
  - A=8'h01, B=8'h80 → 16'h0080.
  - A=8'h80, B=8'h80 → 16'h4000.
- **Late valid:** requester 3 raises valid while the block is in RESP. Expect no `req_ready_o`; it is granted in the first IDLE cycle after the response is accepted.

Source files
------------

// File: rtl/multiplier_arbiter_pkg.sv
// Shared types for multiplier_arbiter: FSM state encoding and the reset value
// of the round-robin pointer.
package multiplier_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Pointer starts at the last index so requester 0 wins the first search.
  function automatic int ptr_reset(input int num_req);
    return num_req - 1;
  endfunction

endpackage

// File: rtl/multiplier_arbiter_multiplier.sv
// Combinational unsigned multiplier, full-width product.
module multiplier #(
  parameter int Width = 8
) (
  input  logic [Width-1:0]   a,
  input  logic [Width-1:0]   b,
  output logic [2*Width-1:0] product
);

  assign product = {{Width{1'b0}}, a} * {{Width{1'b0}}, b};

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one multiplier among NumReq valid/ready requesters, tagging each response.
// Define MULTIPLIER_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority.
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter  int Width  = 8,
  parameter  int NumReq = 4,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*Width-1:0] req_a_i,
  input  logic [NumReq*Width-1:0] req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IdW-1:0]          rsp_id_o,
  output logic [2*Width-1:0]      rsp_data_o,
  output logic                    busy_o
);

  state_e               state_q, state_d;
  logic [Width-1:0]     a_q, b_q;
  logic [IdW-1:0]       id_q;
  logic [2*Width-1:0]   data_q;
  logic [2*Width-1:0]   product;
  logic [IdW-1:0]       grant_idx;
  logic                 grant_found;
  logic                 accept;
  int                   cand;

`ifdef MULTIPLIER_ARBITER_RR_EN
  logic [IdW-1:0]       ptr_q;
`endif

  // Arbitration: first valid requester in search order.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NumReq; i++) begin
`ifdef MULTIPLIER_ARBITER_RR_EN
      cand = int'(ptr_q) + 1 + i;
      if (cand >= NumReq) cand = cand - NumReq;
`else
      cand = i;
`endif
      if (!grant_found && req_valid_i[IdW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IdW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found && rst_ni) begin
          req_ready_o[grant_idx] = 1'b1;
          accept                 = 1'b1;
          state_d                = MUL;
        end
      end
      MUL:     state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= req_a_i[grant_idx*Width +: Width];
        b_q  <= req_b_i[grant_idx*Width +: Width];
        id_q <= grant_idx;
      end
      if (state_q == MUL) data_q <= product;
    end
  end

`ifdef MULTIPLIER_ARBITER_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= IdW'(ptr_reset(NumReq));
    else if (accept) ptr_q <= grant_idx;
  end
`endif

  multiplier #(.Width(Width)) u_multiplier (
    .a       (a_q),
    .b       (b_q),
    .product (product)
  );

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);

endmodule
